uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, optional even/odd parity,
// one or two stop bits. Byte handshake on valid/ready; Tx is registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Data,
    input  logic       valid,
    output logic       ready,
    output logic       Tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] CNT_MAX    = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);
    localparam logic        HAS_PARITY = (PARITY != 0);
    localparam logic        PAR_ODD    = (PARITY == 2);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        par_reg, par_next;
    logic        tx_reg, tx_next;

    logic wrap;
    logic last_stop;
    logic accept;

    // Handshake and status decode from the current state.
    always_comb begin
        wrap      = (cnt_reg == CNT_MAX);
        last_stop = (state_reg == S_STOP) && wrap && (bit_reg == LAST_STOP);
        ready     = (state_reg == S_IDLE) || last_stop;
        accept    = valid && ready;
        busy      = (state_reg != S_IDLE);
        done      = last_stop && !rst;
        Tx        = tx_reg;
    end

    // Next-state logic; Tx for the next cycle is derived from the next state
    // so the line changes exactly on bit boundaries.
    always_comb begin
        state_next = state_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        cnt_next   = (state_reg == S_IDLE || wrap) ? 16'd0 : cnt_reg + 16'd1;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_START;
                    shift_next = Data;
                    par_next   = (^Data) ^ PAR_ODD;
                    bit_next   = 3'd0;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_next = S_DATA;
                    bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == 3'd7) begin
                        bit_next   = 3'd0;
                        state_next = HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_next = S_STOP;
                    bit_next   = 3'd0;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (bit_reg == LAST_STOP) begin
                        // A byte offered in the final stop cycle starts the
                        // next frame immediately, with no idle gap.
                        if (accept) begin
                            state_next = S_START;
                            shift_next = Data;
                            par_next   = (^Data) ^ PAR_ODD;
                        end else begin
                            state_next = S_IDLE;
                        end
                        bit_next = 3'd0;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame in flight and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 16'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four instances (no parity, even, odd, two stop bits)
// share one stimulus stream; a frame-level model predicts every output.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int N   = 4;
    localparam int LOG = 8192;

    logic         clk;
    logic         rst;
    logic         valid;
    logic [7:0]   Data;
    logic [N-1:0] ready_w, tx_w, busy_w, done_w;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            uart_tx #(
                .CLKS_PER_BIT(CPB),
                .PARITY      (gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
                .STOP_BITS   (gi == 3 ? 2 : 1)
            ) dut (
                .clk  (clk),
                .rst  (rst),
                .Data (Data),
                .valid(valid),
                .ready(ready_w[gi]),
                .Tx   (tx_w[gi]),
                .busy (busy_w[gi]),
                .done (done_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each instance is either idle or at cycle 'pos' of a frame whose
    // line levels are frm[bit], one bit per CPB cycles, len cycles in total.
    bit          act [N];
    int          pos [N];
    int          len [N];
    int          acc_cyc [N];
    int          last_lat [N];
    logic [11:0] frm [N];

    logic [N-1:0] tx_log    [LOG];
    logic [N-1:0] busy_log  [LOG];
    logic [N-1:0] ready_log [LOG];
    logic [N-1:0] done_log  [LOG];

    int total, bad, cyc;

    function automatic int par_of(int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int stop_of(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Line levels of a frame: start 0, data LSB first, parity, then ones.
    function automatic logic [11:0] frame_of(logic [7:0] d, int p);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (p == 1) f[9] = ^d;
        if (p == 2) f[9] = ~(^d);
        return f;
    endfunction

    function automatic int len_of(int p, int s);
        return (9 + ((p != 0) ? 1 : 0) + s) * CPB;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, got, want);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs, then advance model.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic acc [N];
        valid = v;
        Data  = d;
        rst   = r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            logic e_tx, e_busy, e_ready, e_done;
            if (act[i]) begin
                e_tx    = frm[i][pos[i] / CPB];
                e_busy  = 1'b1;
                e_done  = (pos[i] == len[i] - 1);
                e_ready = e_done;
            end else begin
                e_tx    = 1'b1;
                e_busy  = 1'b0;
                e_done  = 1'b0;
                e_ready = 1'b1;
            end
            if (cyc < LOG) begin
                tx_log[cyc][i]    = tx_w[i];
                busy_log[cyc][i]  = busy_w[i];
                ready_log[cyc][i] = ready_w[i];
                done_log[cyc][i]  = done_w[i] && !r;
            end
            if (!r) begin
                check("tx", i, 32'(tx_w[i]), 32'(e_tx));
                check("busy", i, 32'(busy_w[i]), 32'(e_busy));
                check("ready", i, 32'(ready_w[i]), 32'(e_ready));
                check("done", i, 32'(done_w[i]), 32'(e_done));
                if (done_w[i] === 1'b1) last_lat[i] = cyc - acc_cyc[i];
            end
            acc[i] = v && e_ready && !r;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                act[i] = 1'b0;
            end else begin
                if (act[i]) begin
                    pos[i]++;
                    if (pos[i] == len[i]) act[i] = 1'b0;
                end
                if (acc[i]) begin
                    act[i]     = 1'b1;
                    pos[i]     = 0;
                    frm[i]     = frame_of(d, par_of(i));
                    len[i]     = len_of(par_of(i), stop_of(i));
                    acc_cyc[i] = cyc;
                end
            end
        end
        cyc++;
        #1;
    endtask

    // Stimulus: reset, directed frames, then randomized traffic.
    initial begin
        int a, cnt0, cnt1;
        logic [9:0]  exp0;
        logic [11:0] f;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        valid = 1'b0;
        Data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; pos[i] = 0; len[i] = 0; acc_cyc[i] = 0; last_lat[i] = -1;
        end
        @(posedge clk);
        #1;

        // Hand-computed frames pin the model.
        exp0 = 10'b1011001010;
        f = frame_of(8'h65, 0);
        check("model_0x65", -1, 32'(f[9:0]), 32'(exp0));
        check("model_len40", -1, 32'(len_of(0, 1)), 32'd40);
        f = frame_of(8'h02, 1);
        check("model_even", -1, 32'(f[9]), 32'd1);
        f = frame_of(8'h02, 2);
        check("model_odd", -1, 32'(f[9]), 32'd0);
        check("model_len44", -1, 32'(len_of(0, 2)), 32'd44);

        repeat (3) step(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < N; i++) begin
            check("rst_tx", i, 32'(tx_w[i]), 32'd1);
            check("rst_ready", i, 32'(ready_w[i]), 32'd1);
            check("rst_busy", i, 32'(busy_w[i]), 32'd0);
        end

        // 0x65, single frame.
        a = cyc;
        step(1'b1, 8'h65, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
                check("bits_0x65", 0, 32'(tx_log[a + 1 + CPB * k + j][0]), 32'(exp0[k]));
        check("lat_p0", 0, 32'(last_lat[0]), 32'd40);
        check("lat_p1", 1, 32'(last_lat[1]), 32'd44);
        check("lat_s2", 3, 32'(last_lat[3]), 32'd44);
        check("ready_a40", 0, 32'(ready_log[a + 40][0]), 32'd1);
        check("ready_a39", 0, 32'(ready_log[a + 39][0]), 32'd0);

        // 0x02 with parity.
        a = cyc;
        step(1'b1, 8'h02, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0);
        check("even_par", 1, 32'(tx_log[a + 37][1]), 32'd1);
        check("odd_par", 2, 32'(tx_log[a + 37][2]), 32'd0);
        check("lat_even", 1, 32'(last_lat[1]), 32'd44);

        // 0x00 with two stop bits.
        a = cyc;
        step(1'b1, 8'h00, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0);
        cnt0 = 0;
        cnt1 = 0;
        for (int c = a + 1; c <= a + 36; c++) if (tx_log[c][3] == 1'b0) cnt0++;
        for (int c = a + 37; c <= a + 44; c++) if (tx_log[c][3] == 1'b1) cnt1++;
        check("stop2_zeros", 3, 32'(cnt0), 32'd36);
        check("stop2_ones", 3, 32'(cnt1), 32'd8);
        check("lat_stop2", 3, 32'(last_lat[3]), 32'd44);

        // Back-to-back: valid held, Data switched at the first done.
        a = cyc;
        step(1'b1, 8'h65, 1'b0);
        for (int c = 1; c < 40; c++) step(1'b1, 8'h65, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        repeat (50) step(1'b0, 8'h00, 1'b0);
        check("b2b_done1", 0, 32'(done_log[a + 40][0]), 32'd1);
        check("b2b_done2", 0, 32'(done_log[a + 80][0]), 32'd1);
        check("b2b_start", 0, 32'(tx_log[a + 41][0]), 32'd0);
        check("b2b_bit1", 0, 32'(tx_log[a + 49][0]), 32'd1);

        // Data toggled while a frame is in flight.
        a = cyc;
        step(1'b1, 8'h65, 1'b0);
        for (int c = 1; c < 40; c++) step(1'b1, (c % 2 == 1) ? 8'hFF : 8'h00, 1'b0);
        repeat (30) step(1'b0, 8'h00, 1'b0);
        cnt0 = 0;
        cnt1 = 0;
        for (int c = a + 1; c <= a + 69; c++) if (done_log[c][0]) cnt0++;
        for (int c = a + 1; c <= a + 39; c++) if (ready_log[c][0]) cnt1++;
        check("toggle_dones", 0, 32'(cnt0), 32'd1);
        check("toggle_ready", 0, 32'(cnt1), 32'd0);

        // Reset in the middle of a frame.
        a = cyc;
        step(1'b1, 8'h65, 1'b0);
        repeat (19) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        repeat (60) step(1'b0, 8'h00, 1'b0);
        check("abort_tx", 0, 32'(tx_log[a + 21][0]), 32'd1);
        check("abort_busy", 0, 32'(busy_log[a + 21][0]), 32'd0);
        check("abort_ready", 0, 32'(ready_log[a + 21][0]), 32'd1);
        cnt0 = 0;
        for (int c = a + 1; c <= a + 80; c++) if (done_log[c][0]) cnt0++;
        check("abort_nodone", 0, 32'(cnt0), 32'd0);

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            logic rv, rr;
            logic [7:0] rd;
            rv = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom);
            rr = ($urandom_range(0, 199) == 0);
            step(rv, rd, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
